// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for HI/LO-class operations: drives the pipelined multiplier
// and the iterative divider, stalls EX until the result is ready, commits HI/LO once.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic        op_mul,
    input  logic        op_mulu,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        stallreq,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        hi_we,
    output logic [31:0] hi_wdata,
    output logic        lo_we,
    output logic [31:0] lo_wdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        sgn_q, sgn_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;

    logic is_mul, is_div, start_ok;

    assign is_mul   = op_mul | op_mulu;
    assign is_div   = op_div | op_divu;
    assign start_ok = op_valid & ~flush;

    // Flush wins over every other event; outputs are decoded from state and inputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sgn_d       = sgn_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        stallreq    = 1'b0;
        mul_signed  = 1'b0;
        mul_ina     = 32'd0;
        mul_inb     = 32'd0;
        div_start   = 1'b0;
        div_signed  = 1'b0;
        div_opdata1 = 32'd0;
        div_opdata2 = 32'd0;
        div_annul   = 1'b0;
        hi_we       = 1'b0;
        hi_wdata    = 32'd0;
        lo_we       = 1'b0;
        lo_wdata    = 32'd0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (is_mul) begin
                        stallreq   = 1'b1;
                        opa_d      = src1;
                        opb_d      = src2;
                        sgn_d      = op_mul;
                        cnt_d      = CNT_INIT;
                        state_d    = MUL_WAIT;
                        // Present operands now so the multiplier latency starts this cycle.
                        mul_signed = op_mul;
                        mul_ina    = src1;
                        mul_inb    = src2;
                    end else if (is_div) begin
                        stallreq = 1'b1;
                        if (src2 != 32'd0) begin
                            opa_d   = src1;
                            opb_d   = src2;
                            sgn_d   = op_div;
                            state_d = DIV_BUSY;
                        end else begin
                            res_hi_d = src1;
                            res_lo_d = 32'hFFFF_FFFF;
                            state_d  = DONE;
                        end
                    end else if (!ex_hold) begin
                        hi_we    = op_mthi;
                        hi_wdata = op_mthi ? src1 : 32'd0;
                        lo_we    = op_mtlo;
                        lo_wdata = op_mtlo ? src1 : 32'd0;
                    end
                end
            end

            MUL_WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    stallreq   = 1'b1;
                    mul_signed = sgn_q;
                    mul_ina    = opa_q;
                    mul_inb    = opb_q;
                    if (cnt_q == 4'd0) begin
                        res_hi_d = mul_result[63:32];
                        res_lo_d = mul_result[31:0];
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            DIV_BUSY: begin
                if (flush) begin
                    div_annul = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stallreq    = 1'b1;
                    div_signed  = sgn_q;
                    div_opdata1 = opa_q;
                    div_opdata2 = opb_q;
                    if (div_ready) begin
                        res_hi_d = div_result[63:32];
                        res_lo_d = div_result[31:0];
                        state_d  = DONE;
                    end else begin
                        div_start = 1'b1;
                    end
                end
            end

            DONE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!ex_hold) begin
                    hi_we    = 1'b1;
                    hi_wdata = res_hi_q;
                    lo_we    = 1'b1;
                    lo_wdata = res_lo_q;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            sgn_q    <= 1'b0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sgn_q    <= sgn_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider models and a
// scoreboard of expected HI/LO writes checked whenever the DUT writes.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid, op_mul, op_mulu, op_div, op_divu, op_mthi, op_mtlo;
    logic [31:0] src1, src2;
    logic        ex_hold, flush;
    logic        stallreq, mul_signed, div_start, div_signed, div_annul, div_ready;
    logic [31:0] mul_ina, mul_inb, div_opdata1, div_opdata2;
    logic [63:0] mul_result, div_result;
    logic        hi_we, lo_we, busy;
    logic [31:0] hi_wdata, lo_wdata;

    typedef struct packed {
        logic        hwe;
        logic        lwe;
        logic [31:0] hi;
        logic [31:0] lo;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  stall_cycles, start_cycles, annul_cycles, write_count;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid),
        .op_mul(op_mul), .op_mulu(op_mulu), .op_div(op_div), .op_divu(op_divu),
        .op_mthi(op_mthi), .op_mtlo(op_mtlo), .src1(src1), .src2(src2),
        .ex_hold(ex_hold), .flush(flush), .stallreq(stallreq),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2), .div_annul(div_annul),
        .div_ready(div_ready), .div_result(div_result),
        .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata),
        .busy(busy)
    );

    // Multiplier model: product registered through MUL_LAT stages.
    logic [63:0] mpipe [0:MUL_LAT-1];
    logic [63:0] mprod;
    always_comb begin
        if (mul_signed)
            mprod = $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb});
        else
            mprod = {32'd0, mul_ina} * {32'd0, mul_inb};
    end
    always @(posedge clk) begin
        mpipe[0] <= mprod;
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[MUL_LAT-1];

    // Divider model: ready one cycle after DIV_CYC consecutive start cycles.
    int          dcnt;
    logic        dready;
    logic [31:0] da, db;
    logic        dsgn;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dcnt <= 0; dready <= 1'b0; da <= 32'd0; db <= 32'd1; dsgn <= 1'b0;
        end else if (div_annul || !div_start) begin
            dcnt <= 0; dready <= 1'b0;
        end else begin
            if (dcnt == 0) begin
                da <= div_opdata1; db <= div_opdata2; dsgn <= div_signed;
            end
            dcnt   <= dcnt + 1;
            dready <= (dcnt == DIV_CYC - 1);
        end
    end
    assign div_ready = dready;
    always_comb begin
        if (dsgn)
            div_result = {32'($signed(da) % $signed(db)), 32'($signed(da) / $signed(db))};
        else
            div_result = {da % db, da / db};
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Activity counters and scoreboard comparison on every HI/LO write.
    always @(negedge clk) begin
        if (resetn) begin
            if (stallreq)  stall_cycles++;
            if (div_start) start_cycles++;
            if (div_annul) annul_cycles++;
            if (hi_we || lo_we) begin
                wr_t obs;
                write_count++;
                obs = '{hwe: hi_we, lwe: lo_we,
                        hi: hi_we ? hi_wdata : 32'd0, lo: lo_we ? lo_wdata : 32'd0};
                if (sb.size() == 0) check_output("sb_unexpected", {hi_we, lo_we}, 0);
                else check_output("sb_write", obs, sb.pop_front());
            end
        end
    end

    task automatic clear_counts();
        stall_cycles = 0; start_cycles = 0; annul_cycles = 0; write_count = 0;
    endtask

    task automatic clear_inputs();
        op_valid = 0; op_mul = 0; op_mulu = 0; op_div = 0; op_divu = 0;
        op_mthi = 0; op_mtlo = 0; src1 = 0; src2 = 0; ex_hold = 0; flush = 0;
    endtask

    // ops = {mul, mulu, div, divu, mthi, mtlo}
    task automatic apply_stimulus(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b);
        {op_mul, op_mulu, op_div, op_divu, op_mthi, op_mtlo} = ops;
        src1 = a; src2 = b; op_valid = 1'b1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic wait_commit(input int budget);
        int n = 0;
        while (write_count == 0 && n < budget) begin sample(); n++; end
    endtask

    task automatic retire();
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        clear_counts();
        resetn = 1'b0;
        #3;
        check_output("reset_outs",
            {stallreq, busy, hi_we, lo_we, div_start, div_annul, mul_signed, div_signed,
             mul_ina, mul_inb, div_opdata1, div_opdata2}, 0);
        @(negedge clk); resetn = 1'b1;
        sample();
        check_output("idle_after_reset", {busy, stallreq}, 0);

        $display("[TB] mult -3 * 7");
        @(posedge clk); #1; clear_counts();
        sb.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        apply_stimulus(6'b100000, -32'sd3, 32'd7);
        wait_commit(20);
        check_output("mult_writes", write_count, 1);
        check_output("mult_stall", stall_cycles, MUL_LAT + 1);
        retire();
        sample();
        check_output("mult_idle", {busy, stallreq, hi_we, lo_we}, 0);

        $display("[TB] divu 100 / 7");
        @(posedge clk); #1; clear_counts();
        sb.push_back('{1'b1, 1'b1, 32'd2, 32'd14});
        apply_stimulus(6'b000100, 32'd100, 32'd7);
        wait_commit(60);
        check_output("divu_writes", write_count, 1);
        check_output("divu_start", start_cycles, DIV_CYC);
        check_output("divu_stall", stall_cycles, DIV_CYC + 2);
        retire();

        $display("[TB] div 5 / 0");
        @(posedge clk); #1; clear_counts();
        sb.push_back('{1'b1, 1'b1, 32'd5, 32'hFFFF_FFFF});
        apply_stimulus(6'b001000, 32'd5, 32'd0);
        wait_commit(10);
        check_output("div0_writes", write_count, 1);
        check_output("div0_stall", stall_cycles, 1);
        check_output("div0_start", start_cycles, 0);
        retire();

        $display("[TB] div -7 / 2");
        @(posedge clk); #1; clear_counts();
        sb.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        apply_stimulus(6'b001000, -32'sd7, 32'd2);
        wait_commit(60);
        check_output("divs_writes", write_count, 1);
        check_output("divs_stall", stall_cycles, DIV_CYC + 2);
        retire();

        $display("[TB] divu flushed mid-operation");
        @(posedge clk); #1; clear_counts();
        apply_stimulus(6'b000100, 32'd100, 32'd7);
        for (int n = 0; n < 30 && start_cycles < 10; n++) sample();
        check_output("flush_started", start_cycles, 10);
        @(posedge clk); #1; flush = 1'b1;
        sample();
        check_output("flush_cycle", {div_annul, div_start, stallreq, hi_we, lo_we}, 5'b10000);
        retire();
        sample();
        check_output("flush_idle", {busy, stallreq, div_annul}, 0);
        check_output("flush_counts", {annul_cycles, write_count}, {32'd1, 32'd0});

        $display("[TB] multu held in DONE by ex_hold");
        @(posedge clk); #1; clear_counts();
        sb.push_back('{1'b1, 1'b1, 32'd1, 32'hFFFF_FFFE});
        apply_stimulus(6'b010000, 32'hFFFF_FFFF, 32'd2);
        ex_hold = 1'b1;
        sample();
        for (int n = 0; n < 20 && !(busy && !stallreq); n++) sample();
        check_output("hold_done", {busy, stallreq}, 2'b10);
        repeat (3) sample();
        check_output("hold_nowrite", {busy, write_count}, {1'b1, 32'd0});
        @(posedge clk); #1; ex_hold = 1'b0;
        wait_commit(5);
        check_output("hold_writes", write_count, 1);
        check_output("hold_stall", stall_cycles, MUL_LAT + 1);
        retire();

        $display("[TB] mthi / mtlo");
        @(posedge clk); #1; clear_counts();
        sb.push_back('{1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0});
        apply_stimulus(6'b000010, 32'hDEAD_BEEF, 32'd0);
        sample();
        check_output("mthi", {stallreq, busy, write_count}, {2'b00, 32'd1});
        retire();
        @(posedge clk); #1; clear_counts();
        apply_stimulus(6'b000010, 32'hDEAD_BEEF, 32'd0);
        flush = 1'b1;
        sample();
        check_output("mthi_flush", {stallreq, hi_we, lo_we, write_count}, 0);
        retire();
        @(posedge clk); #1; clear_counts();
        sb.push_back('{1'b0, 1'b1, 32'd0, 32'h1234_5678});
        apply_stimulus(6'b000001, 32'h1234_5678, 32'd0);
        sample();
        check_output("mtlo", {stallreq, write_count}, {1'b0, 32'd1});
        retire();

        $display("[TB] reset during divide");
        @(posedge clk); #1; clear_counts();
        apply_stimulus(6'b000100, 32'd9, 32'd3);
        repeat (5) sample();
        resetn = 1'b0;
        clear_inputs();
        #1;
        check_output("reset_mid", {busy, stallreq, div_start, hi_we, lo_we}, 0);
        @(negedge clk); resetn = 1'b1;
        sample();
        check_output("reset_mid_writes", {busy, write_count}, 0);

        check_output("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
